tc0480scp_rom_cache: RTL
========================

Name: tc0480scp_rom_cache

Overview:
- Direct-mapped read cache between the tilemap chip's 64-bit tile ROM fetch port and the SDRAM ROM channel.
- Sits directly upstream of the tilemap chip. It answers that chip's toggle-handshake rom_req/rom_ack requests.
- Repeated fetches of the same tile row within a frame are served locally, so only misses go to SDRAM.
- The memory side uses the same toggle handshake.

Parameters:
- ADDR_W, 23, byte address width of the ROM request; bits [2:0] are always 0 (64-bit aligned).
- INDEX_BITS, 8, log2 of the cache entry count; one entry holds one 64-bit word.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  one-cycle pulse that invalidates all entries (driven at frame start / ROM bank change)
- rom_address  in  ADDR_W  client fetch address
- rom_req  in  1  client request toggle
- rom_ack  out  1  client ack toggle; equals rom_req when rom_data is valid
- rom_data  out  64  client read data
- mem_address  out  ADDR_W  SDRAM fetch address
- mem_req  out  1  SDRAM request toggle
- mem_ack  in  1  SDRAM ack toggle
- mem_data  in  64  SDRAM read data, valid when mem_ack==mem_req
- hit_count  out  16  hit counter (see Optional Feature)
- miss_count  out  16  miss counter (see Optional Feature)

Behaviour:
- Reset (async, reset_n low):
  - rom_ack=0, mem_req=0, rom_data=0, mem_address=0, counters=0.
  - FSM enters FLUSH with sweep index 0.
- Address split:
  - index = rom_address[INDEX_BITS+2:3]
  - tag = rom_address[ADDR_W-1:INDEX_BITS+3]
  - Tag/valid storage is synchronous-read block RAM, one-cycle read latency.
- A pending request is rom_req != rom_ack. On acceptance the address is latched; rom_address may change afterwards.
- FSM states:
  - FLUSH: clear valid[sweep]; sweep+1 per cycle; after entry 2^INDEX_BITS-1 go to IDLE. Takes exactly 2^INDEX_BITS cycles.
  - IDLE:
    - flush pulse -> FLUSH with sweep=0.
    - Otherwise, if a request is pending: latch address, issue the tag/data RAM read, go to LOOKUP.
    - flush has priority over a simultaneous pending request; the request stays pending and is served after FLUSH.
  - LOOKUP:
    - valid && tag match -> rom_data<=stored word, rom_ack<=rom_req, go to IDLE. Hit latency is 2 cycles from the pending edge to the ack toggle.
    - Otherwise mem_address<=latched address, mem_req<=~mem_req, go to MISS_WAIT.
  - MISS_WAIT, on mem_ack==mem_req:
    - Write mem_data, tag and valid=1 at the index.
    - rom_data<=mem_data, rom_ack<=rom_req, go to IDLE.
- flush during LOOKUP or MISS_WAIT:
  - Recorded in a sticky flag and never dropped.
  - The in-flight request still completes and is returned to the client.
  - The fill is still written, then the FSM goes to FLUSH instead of IDLE. The just-filled entry is therefore invalidated.
- flush during FLUSH restarts the sweep at 0.
- Requests pending during FLUSH are held (rom_ack unchanged) until the sweep ends.
- Same index, different tag: the old entry is overwritten on fill (no associativity).
- Data written into the cache is exactly mem_data, with no byte swizzle. Deswizzling stays in the consumer.
- At most one SDRAM request is outstanding. mem_req toggles only in LOOKUP on a miss.
- Reset mid-operation:
  - All state returns to reset values and a full flush runs.
  - An outstanding SDRAM toggle is abandoned. The SDRAM side must also be reset together with this block.
- Client address bits [2:0] are ignored.

Optional Feature:
- Macro TC0480SCP_ROM_CACHE_STATS_EN.
- Defined:
  - hit_count increments on each LOOKUP hit; miss_count increments on each LOOKUP miss.
  - Both are 16-bit, saturate at 16'hFFFF, and are cleared by reset and by a flush pulse.
- Not defined: hit_count and miss_count are constant 0, and no counter logic is generated.

Test Plan:
- Reset, then wait 256 cycles; rom_address=23'h001238, toggle rom_req -> exactly one mem_req toggle with mem_address=23'h001238. Bench returns mem_data=64'h0123456789ABCDEF -> rom_ack toggles, rom_data=64'h0123456789ABCDEF.
- Repeat 23'h001238 -> no mem_req toggle; rom_ack toggles 2 cycles after rom_req with the same data; hit_count=1, miss_count=1 (stats enabled).
- Conflict: 23'h001238 then 23'h009238 (same index, different tag) -> two misses. Then 23'h001238 again -> third miss, served from SDRAM.
- Pulse flush during MISS_WAIT for 23'h000400 -> client still receives the fill data. The next request for 23'h000400 is a miss, and its rom_ack comes no earlier than 256 cycles after the first fill completes.
- flush and a rom_req toggle in the same IDLE cycle -> rom_ack stays unchanged for 256 cycles, then the request is served as a miss.
- Assert reset_n low while in MISS_WAIT -> rom_ack, mem_req and rom_data are immediately 0, and a full flush sweep follows release.

Source files
------------

// File: rtl/tc0480scp_rom_cache.sv
// Direct-mapped 64-bit tile ROM read cache between the tilemap fetch port and SDRAM.
// Optional hit/miss counters are built when TC0480SCP_ROM_CACHE_STATS_EN is defined.
module tc0480scp_rom_cache #(
  parameter int ADDR_W     = 23,
  parameter int INDEX_BITS = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rom_address,
  input  logic              rom_req,
  output logic              rom_ack,
  output logic [63:0]       rom_data,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [63:0]       mem_data,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);
  localparam int DEPTH = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_W - INDEX_BITS - 3;

  typedef enum logic [1:0] {S_FLUSH, S_IDLE, S_LOOKUP, S_MISS_WAIT} state_t;

  state_t                  state, state_nxt;
  logic [INDEX_BITS-1:0]   sweep;
  logic [ADDR_W-1:0]       addr_q;
  logic                    flush_pend;

  logic [INDEX_BITS-1:0]   idx_in, idx_q, wr_idx;
  logic [TAG_W-1:0]        tag_q;
  logic [TAG_W:0]          tag_rd, tag_wdata;
  logic [63:0]             data_rd;
  logic                    pending, hit, fill_done, flush_any;
  logic                    accept, do_hit, do_miss, do_fill, clear_ent, tag_we;

  // tag RAM entry is {valid, tag}
  logic [TAG_W:0]          tag_ram  [DEPTH];
  logic [63:0]             data_ram [DEPTH];

  assign idx_in    = rom_address[INDEX_BITS+2:3];
  assign idx_q     = addr_q[INDEX_BITS+2:3];
  assign tag_q     = addr_q[ADDR_W-1:INDEX_BITS+3];
  assign pending   = rom_req != rom_ack;
  assign hit       = tag_rd[TAG_W] && (tag_rd[TAG_W-1:0] == tag_q);
  assign fill_done = mem_ack == mem_req;
  assign flush_any = flush | flush_pend;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    do_hit    = 1'b0;
    do_miss   = 1'b0;
    do_fill   = 1'b0;
    clear_ent = 1'b0;
    case (state)
      S_FLUSH: begin
        clear_ent = 1'b1;
        if (!flush && sweep == '1) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (flush) state_nxt = S_FLUSH;
        else if (pending) begin
          accept    = 1'b1;
          state_nxt = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          do_hit    = 1'b1;
          state_nxt = flush_any ? S_FLUSH : S_IDLE;
        end else begin
          do_miss   = 1'b1;
          state_nxt = S_MISS_WAIT;
        end
      end
      S_MISS_WAIT: begin
        if (fill_done) begin
          do_fill   = 1'b1;
          state_nxt = flush_any ? S_FLUSH : S_IDLE;
        end
      end
      default: state_nxt = S_FLUSH;
    endcase
  end

  // Single write port shared by the invalidate sweep and miss fills.
  assign tag_we    = clear_ent | do_fill;
  assign wr_idx    = clear_ent ? sweep : idx_q;
  assign tag_wdata = clear_ent ? '0 : {1'b1, tag_q};

  always_ff @(posedge clk) begin
    if (tag_we)  tag_ram[wr_idx]  <= tag_wdata;
    if (do_fill) data_ram[idx_q]  <= mem_data;
    if (accept) begin
      tag_rd  <= tag_ram[idx_in];
      data_rd <= data_ram[idx_in];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_FLUSH;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sweep       <= '0;
      addr_q      <= '0;
      flush_pend  <= 1'b0;
      rom_ack     <= 1'b0;
      rom_data    <= '0;
      mem_address <= '0;
      mem_req     <= 1'b0;
    end else begin
      // a flush arriving mid-sweep restarts it from entry 0
      if (state_nxt == S_FLUSH && (state != S_FLUSH || flush)) sweep <= '0;
      else if (state == S_FLUSH)                                sweep <= sweep + 1'b1;

      if (state_nxt == S_FLUSH)                                      flush_pend <= 1'b0;
      else if (flush && (state == S_LOOKUP || state == S_MISS_WAIT)) flush_pend <= 1'b1;

      if (accept) addr_q <= rom_address;
      if (do_hit) begin
        rom_data <= data_rd;
        rom_ack  <= rom_req;
      end
      if (do_miss) begin
        mem_address <= addr_q;
        mem_req     <= ~mem_req;
      end
      if (do_fill) begin
        rom_data <= mem_data;
        rom_ack  <= rom_req;
      end
    end
  end

`ifdef TC0480SCP_ROM_CACHE_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (flush) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (do_hit  && hit_count  != 16'hFFFF) hit_count  <= hit_count  + 16'd1;
      if (do_miss && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule
